// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector benches.
// State encodings and parameter defaults live here so both ends agree on them.
package seq_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_LEN_W   = 4;
    localparam int SEQ_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_bit_cnt.sv
// Loadable down-counter with a zero flag; nxt_o is the value after the coming edge.
// Latency: load/decrement take effect on the next clock; no backpressure.
module seq_bit_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic [W-1:0] nxt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nxt_o  = cnt_d;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first with repeats and gaps.
// Latency: start at edge N gives the first bit in the cycle after N; no backpressure, abort cancels.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int LEN_W   = SEQ_LEN_W,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   reps,
    input  logic [CNT_W-1:0]   gap,
    output logic               w,
    output logic               w_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seq_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d, len_c;
    logic [CNT_W-1:0]   reps_q, reps_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic               capture;

    logic               idx_ld, idx_dec, idx_zero;
    logic [LEN_W-1:0]   idx_ld_val, idx_nxt;
    logic               gap_ld, gap_dec, gap_zero;
    logic [CNT_W-1:0]   gap_nxt;

    logic w_q, w_d, w_valid_q, w_valid_d, busy_q, busy_d, done_q, done_d;

    assign len_c   = (len > MAX_LEN_L) ? MAX_LEN_L : len;
    assign capture = (state_q == IDLE) && start;

    seq_bit_cnt #(.W(LEN_W)) u_idx_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (idx_ld),
        .val_i  (idx_ld_val),
        .dec_i  (idx_dec),
        .nxt_o  (idx_nxt),
        .zero_o (idx_zero)
    );

    seq_bit_cnt #(.W(CNT_W)) u_gap_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (gap_ld),
        .val_i  (gap_q),
        .dec_i  (gap_dec),
        .nxt_o  (gap_nxt),
        .zero_o (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rep_d      = rep_q;
        idx_ld     = 1'b0;
        idx_ld_val = len_q - LEN_W'(1);
        idx_dec    = 1'b0;
        gap_ld     = 1'b0;
        gap_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rep_d      = '0;
                    idx_ld     = 1'b1;
                    idx_ld_val = len_c - LEN_W'(1);
                    state_d    = (len_c == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_zero) begin
                    if (rep_q < reps_q) begin
                        rep_d = rep_q + CNT_W'(1);
                        if (gap_q != '0) begin
                            state_d = GAP;
                            gap_ld  = 1'b1;
                        end else begin
                            idx_ld  = 1'b1;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_dec = 1'b1;
                end
            end
            GAP: begin
                gap_dec = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_nxt == '0 || gap_zero) begin
                    // Counter holds gap..1 across the GAP cycles; leave as it steps to 0.
                    state_d = SEND;
                    idx_ld  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        reps_d = reps_q;
        gap_d  = gap_q;
        if (capture) begin
            pat_d  = pattern;
            len_d  = len_c;
            reps_d = reps;
            gap_d  = gap;
        end
    end

    // Outputs are computed from next state so the registered pins line up with state_q.
    always_comb begin
        w_valid_d = (state_d == SEND);
        busy_d    = (state_d == SEND) || (state_d == GAP);
        done_d    = (state_d == DONE);
        w_d       = w_valid_d && |(pat_d & (MAX_LEN'(1) << idx_nxt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            rep_q     <= rep_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
